timer_counter: RTL

- Memory-mapped countdown timer sitting on the data-memory bus downstream of the CPU's m_data_addr/m_data_wdata/m_data_byteen outputs.
- The bus bridge decodes the address and asserts sel.
- The timer's irq output feeds one bit of the CPU's HWint[5:0], closing the interrupt loop.
- Three word registers: CTRL, PRESET, COUNT.
- Two modes: one-shot with a held interrupt, and auto-reload with a one-cycle interrupt pulse.

---
 rtl/timer_counter_pkg.sv | 32 +++
 rtl/timer_counter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/timer_counter_pkg.sv
// -----------------------------------------------------------------------------
// timer_counter_pkg
// Shared definitions for the memory-mapped countdown timer: FSM state
// encodings, register offsets decoded from addr[3:2], CTRL bit positions
// and the default mode encodings.
// -----------------------------------------------------------------------------
package timer_counter_pkg;

  // Timer sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  // Word offsets as seen on addr[3:2].
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  // CTRL field positions.
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // Mode encodings. Anything other than the reload encoding runs one-shot.
  localparam logic [1:0] MODE_ONESHOT_DEF = 2'b00;
  localparam logic [1:0] MODE_RELOAD_DEF  = 2'b01;

endpackage

// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
// Countdown timer on the data-memory bus. The bridge decodes the address
// and raises sel; the timer decodes addr[3:2] into CTRL / PRESET / COUNT.
// Supports one-shot mode (held interrupt, en self-clears) and auto-reload
// mode (one-cycle interrupt pulse, period PRESET+3).
//
// Ports
//   clk     : system clock, all state updates on the rising edge
//   reset   : asynchronous, active-low reset
//   sel     : chip select from the bus bridge
//   addr    : byte address, only addr[3:2] decoded
//   we      : write strobe
//   byteen  : per-byte write enables
//   wdata   : write data
//   rdata   : combinational read data, independent of sel
//   irq     : interrupt request (CTRL.im & internal flag)
// -----------------------------------------------------------------------------
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter logic [31:0] PRESET_RST  = 32'h0000_0000,
  parameter logic [1:0]  MODE_RELOAD = MODE_RELOAD_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic        wr_eff;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        en;
  logic        reload;
  logic        flag_set;
  logic        flag_fsm_clr;
  logic        en_fsm_clr;

  // Only the word offset matters; the remaining address bits are ignored.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

  // Merge the enabled bytes of new_val into old_val.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  assign wr_eff    = sel & we & (|byteen);
  assign ctrl_wr   = wr_eff & (addr[3:2] == OFF_CTRL) & byteen[0];
  assign preset_wr = wr_eff & (addr[3:2] == OFF_PRESET);
  assign en        = ctrl_q[CTRL_EN];
  assign reload    = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

  // ---------------------------------------------------------------------------
  // Sequencer: next state, COUNT update and interrupt-flag events.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    count_d      = count_q;
    flag_set     = 1'b0;
    flag_fsm_clr = 1'b0;
    en_fsm_clr   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q <= 32'd1) begin
          // PRESET of 0 and 1 both expire here, giving identical timing.
          count_d  = 32'd0;
          flag_set = 1'b1;
          state_d  = ST_INT;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      ST_INT: begin
        state_d = ST_IDLE;
        if (reload) flag_fsm_clr = 1'b1;  // pulse ends; en still set -> reload
        else        en_fsm_clr   = 1'b1;  // one-shot: stop and hold the flag
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register updates from the bus and the sequencer.
  // ---------------------------------------------------------------------------
  always_comb begin
    ctrl_d = ctrl_q;
    if (en_fsm_clr) ctrl_d[CTRL_EN] = 1'b0;
    // A CPU write on the same edge overrides the sequencer's en clear.
    if (ctrl_wr) ctrl_d = wdata[3:0];

    preset_d = preset_wr ? merge_bytes(preset_q, wdata, byteen) : preset_q;

    irq_flag_d = irq_flag_q;
    if (flag_fsm_clr) irq_flag_d = 1'b0;
    // In one-shot mode software acknowledges by writing CTRL or PRESET.
    if (!reload && (ctrl_wr || preset_wr)) irq_flag_d = 1'b0;
    // A new expiry on the same edge must not be lost.
    if (flag_set) irq_flag_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= 4'h0;
      preset_q   <= PRESET_RST;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Read mux, purely from the current registers.
  always_comb begin
    case (addr[3:2])
      OFF_CTRL:   rdata = {28'h0, ctrl_q};
      OFF_PRESET: rdata = preset_q;
      OFF_COUNT:  rdata = count_q;
      default:    rdata = 32'h0;
    endcase
  end

  assign irq = ctrl_q[CTRL_IM] & irq_flag_q;

endmodule
